max7219_receiver: RTL and testbench

- MAX7219-compatible serial receiver: the device end of the 3-wire link our display drivers transmit on (DIN/CLK/LOAD-CS).
- Oversamples the serial pins on the system clock, assembles 16-bit frames, and decodes them into a shadow register file (8 digit rows + control registers).
- Used as an on-FPGA display emulator and as a loopback checker for the transmitter-side blocks. Provides a daisy-chain DOUT like the real part.

---
 rtl/max7219_pkg.sv | 30 +++
 rtl/sync_edge.sv | 28 ++
 rtl/max7219_receiver.sv | 178 +++++++++++++++++
 tb/tb_max7219_receiver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - shared constants and FSM encoding for the MAX7219 receiver
package max7219_pkg;

    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_COMMIT    = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-stage synchronizer with rise/fall pulses
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;
    assign fall = ~chain[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/max7219_receiver.sv
// rtl/max7219_receiver.sv - oversampling MAX7219-compatible serial receiver with shadow registers
module max7219_receiver
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_clk,
    input  logic       io_din,
    input  logic       io_cs,
    output logic       io_dout,
    output logic       frame_valid,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data,
    output logic       frame_err,
    input  logic [2:0] rd_digit,
    output logic [7:0] rd_data,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       display_test
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   din_bit;

    state_t state, next_state;
    logic   do_shift, do_dout, clr_cnt, do_commit;

    logic [FRAME_W-1:0] shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [7:0]         digit [8];

    logic       full_frame, reg_we;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (io_clk),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (io_cs),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Same depth as the clock path so the sampled bit lines up with the detected rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sync <= '0;
        end else begin
            din_sync <= {din_sync[SYNC_STAGES-2:0], io_din};
        end
    end

    assign din_bit = din_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        do_shift   = 1'b0;
        do_dout    = 1'b0;
        clr_cnt    = 1'b0;
        do_commit  = 1'b0;
        case (state)
            // Synced cs resets low, so cs reaching 1 always appears as a rise here.
            ST_WAIT_IDLE: begin
                if (cs_rise) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    next_state = ST_SHIFT;
                    clr_cnt    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    next_state = ST_COMMIT;
                end else begin
                    do_shift = sclk_rise;
                    do_dout  = sclk_fall;
                end
            end
            ST_COMMIT: begin
                do_commit  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_WAIT_IDLE;
        endcase
    end

    assign full_frame = (bit_cnt >= CNT_W'(FRAME_W));
    assign reg_we     = do_commit & full_frame;
    assign cmd_addr   = shift_reg[11:8];
    assign cmd_data   = shift_reg[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            io_dout     <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (clr_cnt) begin
                bit_cnt <= '0;
            end
            if (do_shift) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], din_bit};
                if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (do_dout) begin
                io_dout <= shift_reg[FRAME_W-1];
            end
            if (reg_we) begin
                frame_valid <= 1'b1;
                frame_addr  <= cmd_addr;
                frame_data  <= cmd_data;
            end else if (do_commit && bit_cnt != '0) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                digit[i] <= '0;
            end
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
        end else if (reg_we) begin
            case (cmd_addr)
                ADDR_NOOP: ;
                ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                    digit[3'(cmd_addr - ADDR_DIGIT0)] <= cmd_data;
                ADDR_DECODE:    decode_mode  <= cmd_data;
                ADDR_INTENSITY: intensity    <= cmd_data[3:0];
                ADDR_SCANLIMIT: scan_limit   <= cmd_data[2:0];
                ADDR_SHUTDOWN:  shutdown_n   <= cmd_data[0];
                ADDR_TEST:      display_test <= cmd_data[0];
                default: ;
            endcase
        end
    end

    assign rd_data = digit[rd_digit];

endmodule

// File: tb/tb_max7219_receiver.sv
// tb/tb_max7219_receiver.sv - self-checking bench for max7219_receiver
module tb_max7219_receiver;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;
    localparam int PH   = 6;

    localparam int P_NONE = 0;
    localparam int P_SHDN = 1;
    localparam int P_INT  = 2;
    localparam int P_SCAN = 3;
    localparam int P_TEST = 4;
    localparam int P_DEC  = 5;
    localparam int P_DIG  = 16;

    typedef struct {
        logic [63:0] bits;
        int          n;
        logic        exp_v;
        logic        exp_e;
        logic [3:0]  exp_a;
        logic [7:0]  exp_d;
        int          probe;
        logic [7:0]  exp_p;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, io_clk, io_din, io_cs;
    logic [2:0] rd_digit, c_rd_digit;
    logic       io_dout, frame_valid, frame_err, shutdown_n, display_test;
    logic [3:0] frame_addr, intensity;
    logic [7:0] frame_data, rd_data, decode_mode;
    logic [2:0] scan_limit;

    logic       c_dout, c_valid, c_err, c_shdn, c_test;
    logic [3:0] c_addr, c_int;
    logic [7:0] c_data, c_rd_data, c_dec;
    logic [2:0] c_scan;

    max7219_receiver #(.SYNC_STAGES(SYNC)) u_dut (
        .clk(clk), .rst_n(rst_n), .io_clk(io_clk), .io_din(io_din), .io_cs(io_cs),
        .io_dout(io_dout), .frame_valid(frame_valid), .frame_addr(frame_addr),
        .frame_data(frame_data), .frame_err(frame_err), .rd_digit(rd_digit),
        .rd_data(rd_data), .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test)
    );

    max7219_receiver #(.SYNC_STAGES(SYNC)) u_chain (
        .clk(clk), .rst_n(rst_n), .io_clk(io_clk), .io_din(io_dout), .io_cs(io_cs),
        .io_dout(c_dout), .frame_valid(c_valid), .frame_addr(c_addr),
        .frame_data(c_data), .frame_err(c_err), .rd_digit(c_rd_digit),
        .rd_data(c_rd_data), .decode_mode(c_dec), .intensity(c_int),
        .scan_limit(c_scan), .shutdown_n(c_shdn), .display_test(c_test)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] m_digit [8];
    logic [7:0] m_dec;
    logic [3:0] m_int, m_last_a;
    logic [2:0] m_scan;
    logic       m_shdn, m_test;
    logic [7:0] m_last_d;

    int         got_v, got_e, got_lat;
    logic [3:0] cap_a;
    logic [7:0] cap_d;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_dec = 0; m_int = 0; m_scan = 0; m_shdn = 0; m_test = 0;
        m_last_a = 0; m_last_d = 0;
    endtask

    task automatic m_apply(input logic [15:0] w);
        int a;
        a = int'(w[11:8]);
        m_last_a = w[11:8];
        m_last_d = w[7:0];
        if (a >= 1 && a <= 8) m_digit[a-1] = w[7:0];
        else if (a == 9)  m_dec  = w[7:0];
        else if (a == 10) m_int  = w[3:0];
        else if (a == 11) m_scan = w[2:0];
        else if (a == 12) m_shdn = w[0];
        else if (a == 15) m_test = w[0];
    endtask

    task automatic check_regs();
        for (int d = 0; d < 8; d++) begin
            @(negedge clk);
            rd_digit = 3'(d);
            #1;
            check($sformatf("digit%0d", d), 32'(rd_data), 32'(m_digit[d]));
        end
        check("decode_mode", 32'(decode_mode), 32'(m_dec));
        check("intensity", 32'(intensity), 32'(m_int));
        check("scan_limit", 32'(scan_limit), 32'(m_scan));
        check("shutdown_n", 32'(shutdown_n), 32'(m_shdn));
        check("display_test", 32'(display_test), 32'(m_test));
        check("frame_addr_hold", 32'(frame_addr), 32'(m_last_a));
        check("frame_data_hold", 32'(frame_data), 32'(m_last_d));
    endtask

    task automatic start_frame();
        @(negedge clk);
        io_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            io_din = v[i];
            repeat (PH) @(negedge clk);
            io_clk = 1'b1;
            repeat (PH) @(negedge clk);
            io_clk = 1'b0;
        end
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        io_cs = 1'b1;
        got_v = 0; got_e = 0; got_lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                got_v++;
                cap_a = frame_addr;
                cap_d = frame_data;
                if (got_lat < 0) got_lat = k;
            end
            if (frame_err) begin
                got_e++;
                if (got_lat < 0) got_lat = k;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] v, input int n);
        start_frame();
        shift_bits(v, n);
        end_frame();
    endtask

    task automatic model_check(input logic [63:0] v, input int n);
        logic [15:0] w;
        w = v[15:0];
        if (n >= 16) begin
            check("valid_pulses", 32'(got_v), 32'd1);
            check("err_pulses", 32'(got_e), 32'd0);
            check("cap_addr", 32'(cap_a), 32'(w[11:8]));
            check("cap_data", 32'(cap_d), 32'(w[7:0]));
            check("latency", 32'(got_lat), 32'(LAT));
            m_apply(w);
        end else if (n > 0) begin
            check("valid_pulses", 32'(got_v), 32'd0);
            check("err_pulses", 32'(got_e), 32'd1);
            check("latency", 32'(got_lat), 32'(LAT));
        end else begin
            check("valid_pulses", 32'(got_v), 32'd0);
            check("err_pulses", 32'(got_e), 32'd0);
        end
        check_regs();
    endtask

    task automatic get_probe(input int p, output logic [7:0] val);
        val = 8'h00;
        if (p >= P_DIG) begin
            @(negedge clk);
            rd_digit = 3'(p - P_DIG);
            #1;
            val = rd_data;
        end else begin
            case (p)
                P_SHDN: val = 8'(shutdown_n);
                P_INT:  val = 8'(intensity);
                P_SCAN: val = 8'(scan_limit);
                P_TEST: val = 8'(display_test);
                P_DEC:  val = decode_mode;
                default: val = 8'h00;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  pv;
        logic [63:0] rv;
        int          rn, r;

        rst_n = 1'b0; io_clk = 1'b0; io_din = 1'b0; io_cs = 1'b1;
        rd_digit = 3'd0; c_rd_digit = 3'd0;
        m_reset();

        tbl[0]  = '{64'h0C01,   16, 1'b1, 1'b0, 4'hC, 8'h01, P_SHDN,    8'h01};
        tbl[1]  = '{64'h0355,   16, 1'b1, 1'b0, 4'h3, 8'h55, P_DIG + 2, 8'h55};
        tbl[2]  = '{64'h08AA,   16, 1'b1, 1'b0, 4'h8, 8'hAA, P_DIG + 7, 8'hAA};
        tbl[3]  = '{64'h0A1F,   16, 1'b1, 1'b0, 4'hA, 8'h1F, P_INT,     8'h0F};
        tbl[4]  = '{64'h0BFF,   16, 1'b1, 1'b0, 4'hB, 8'hFF, P_SCAN,    8'h07};
        tbl[5]  = '{64'hFA07,   16, 1'b1, 1'b0, 4'hA, 8'h07, P_INT,     8'h07};
        tbl[6]  = '{64'hFF01,   16, 1'b1, 1'b0, 4'hF, 8'h01, P_TEST,    8'h01};
        tbl[7]  = '{64'h0123,   12, 1'b0, 1'b1, 4'h0, 8'h00, P_INT,     8'h07};
        tbl[8]  = '{64'hAB0901, 24, 1'b1, 1'b0, 4'h9, 8'h01, P_DEC,     8'h01};
        tbl[9]  = '{64'h0D77,   16, 1'b1, 1'b0, 4'hD, 8'h77, P_DIG + 0, 8'h00};
        tbl[10] = '{64'h0000,    0, 1'b0, 1'b0, 4'h0, 8'h00, P_SHDN,    8'h01};
        tbl[11] = '{64'h0000,   16, 1'b1, 1'b0, 4'h0, 8'h00, P_SCAN,    8'h07};
        tbl[12] = '{64'h3C00,   16, 1'b1, 1'b0, 4'hC, 8'h00, P_SHDN,    8'h00};

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_dout", 32'(io_dout), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_regs();

        for (int i = 0; i < 13; i++) begin
            send(tbl[i].bits, tbl[i].n);
            check($sformatf("vec%0d_valid", i), 32'(got_v), 32'(tbl[i].exp_v));
            check($sformatf("vec%0d_err", i), 32'(got_e), 32'(tbl[i].exp_e));
            if (tbl[i].exp_v) begin
                check($sformatf("vec%0d_addr", i), 32'(cap_a), 32'(tbl[i].exp_a));
                check($sformatf("vec%0d_data", i), 32'(cap_d), 32'(tbl[i].exp_d));
            end
            if (tbl[i].probe != P_NONE) begin
                get_probe(tbl[i].probe, pv);
                check($sformatf("vec%0d_probe", i), 32'(pv), 32'(tbl[i].exp_p));
            end
            model_check(tbl[i].bits, tbl[i].n);
        end

        do_reset();
        check("chain_rst_shdn", 32'(c_shdn), 32'd0);
        send(64'h0C010A05, 32);
        model_check(64'h0C010A05, 32);
        check("first_intensity", 32'(intensity), 32'd5);
        check("chain_shdn", 32'(c_shdn), 32'd1);
        check("chain_addr", 32'(c_addr), 32'hC);
        check("chain_data", 32'(c_data), 32'h01);

        start_frame();
        shift_bits(64'hAB, 8);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        shift_bits(64'hCD, 8);
        end_frame();
        check("midrst_valid", 32'(got_v), 32'd0);
        check("midrst_err", 32'(got_e), 32'd0);
        check_regs();
        send(64'h0C01, 16);
        model_check(64'h0C01, 16);

        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 6)      rn = int'($urandom_range(1, 15));
            else if (r == 7) rn = int'($urandom_range(17, 40));
            else if (r == 8) rn = 0;
            else             rn = 16;
            rv = {$urandom, $urandom};
            send(rv, rn);
            model_check(rv, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
